mul_div_unit: RTL
=================

# mul_div_unit

Iterative 16-bit multiply/divide unit in the execute stage, directly downstream of the register file. It consumes the two read operands (`data1`, `data2`) and a destination register address. It produces a 32-bit result split into `result_hi`/`result_lo`, which writeback uses to drive the register-file write port. `done` serves as the write strobe.

## Interface
Parameters:
- `WIDTH`, 16: operand and result-half width.
- `ADDR_W`, 3: register address width (8 registers).

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: request a new operation. Sampled only when ready (state IDLE or DONE).
- `op`  in  2: operation.
  - 00 MULTU
  - 01 DIVU
  - 10 MULT (signed)
  - 11 DIV (signed)
- `operand_a`  in  WIDTH: multiplicand / dividend (from `data1`).
- `operand_b`  in  WIDTH: multiplier / divisor (from `data2`).
- `dest_addr`  in  ADDR_W: destination register for writeback.
- `kill`  in  1: synchronous abort of the operation in flight.
- `busy`  out  1: operation in progress; `start` is ignored while high.
- `done`  out  1: one-cycle pulse; results valid.
- `result_lo`  out  WIDTH: product[15:0] or quotient.
- `result_hi`  out  WIDTH: product[31:16] or remainder.
- `wr_addr`  out  ADDR_W: `dest_addr` captured at start.
- `div_by_zero`  out  1: valid with `done`; set for a DIV/DIVU with `operand_b` == 0.

## Operation
- FSM states: IDLE, RUN, FIX, DONE.
  - IDLE/DONE → RUN on `start` (and `kill` low). Capture op, operands, and `dest_addr`.
  - RUN lasts exactly WIDTH cycles (step counter 0..WIDTH-1), then → FIX.
  - FIX (1 cycle): apply sign correction and load the output registers, then → DONE.
  - DONE (1 cycle): `done`=1. Go to RUN if `start`, else to IDLE.
- Signed ops: take the magnitudes of the operands at capture, run the unsigned core, negate in FIX.
  - Product sign = a XOR b.
  - Quotient sign = a XOR b.
  - Remainder sign = sign of dividend.
- Multiply: shift-add, one bit per RUN cycle, 2·WIDTH accumulator.
- Divide: restoring shift-subtract, one quotient bit per RUN cycle.
- Divide by zero (either signedness): `result_lo`=0xFFFF, `result_hi`=`operand_a` (unmodified), `div_by_zero`=1. Latency is still normal.
- Signed overflow, DIV 0x8000 / 0xFFFF: `result_lo`=0x8000, `result_hi`=0x0000, `div_by_zero`=0.
- `result_lo`, `result_hi`, `wr_addr`, and `div_by_zero` are registered. They change only on entry to DONE and hold until the next DONE.
- `kill` in RUN or FIX returns the FSM to IDLE on the next edge. No `done`; outputs keep their previous values.
- `kill` and `start` in the same cycle: `kill` wins and the start is dropped.

## Timing
- Reset values: every output is 0 and the state is IDLE. Assertion takes effect immediately, including mid-operation; there is no `done` after release.
- `busy`=1 in RUN and FIX; 0 in IDLE and DONE.
- Latency: if `start` is sampled at edge k, `done` is high in the cycle following edge k+WIDTH+1 (18 cycles for WIDTH=16).
- Back-to-back: `start` asserted during the DONE cycle begins the next operation with no bubble. Throughput is one result per WIDTH+2 cycles.
- Operands may change after the capture edge without effect.

## Structure
- `mdu_pkg` holds:
  - op encodings: `OP_MULTU`, `OP_DIVU`, `OP_MULT`, `OP_DIV`
  - FSM state encoding
  - default `WIDTH`/`ADDR_W`
- One sub-module is natural: `mdu_shift_core`. It contains the shared 2·WIDTH shift register, the adder/subtractor, and the step counter, and takes a mul/div select. Sign handling and the FSM stay in the top level.

## Test plan
- MULTU a=0x00FF, b=0x0101, dest=5 → `done` exactly 18 cycles after start; lo=0xFFFF, hi=0x0000, `wr_addr`=5, `busy` high for cycles 1–17.
- MULT a=0xFFFE (-2), b=0x0003 → lo=0xFFFA, hi=0xFFFF.
- DIVU a=69, b=4 → lo=0x0011, hi=0x0001. DIV a=0xFFF2 (-14), b=4 → lo=0xFFFD, hi=0xFFFE.
- DIVU a=0x000E, b=0 → lo=0xFFFF, hi=0x000E, `div_by_zero`=1. Follow back-to-back (start during DONE) with MULTU 3×4 → lo=0x000C, `div_by_zero`=0, no idle cycle.
- `kill` in RUN cycle 5 → `busy` low next cycle, no `done`, outputs retain the prior result. `start` and `kill` together → operation not started.
- `rst_n` low mid-RUN → all outputs 0 asynchronously; after release, no `done` pulse until a new `start`. DIV 0x8000/0xFFFF → lo=0x8000, hi=0x0000.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings (OP_MULTU, OP_DIVU, OP_MULT, OP_DIV)
//   - FSM state encoding
//   - default operand width and register address width
package mdu_pkg;

    localparam int unsigned MDU_WIDTH  = 16;
    localparam int unsigned MDU_ADDR_W = 3;

    // Bit 0 selects divide, bit 1 selects signed.
    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_DIVU  = 2'b01,
        OP_MULT  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StFix  = 2'b10,
        StDone = 2'b11
    } state_e;

endpackage

// File: rtl/mdu_shift_core.sv
// mdu_shift_core: unsigned shift-add multiplier / restoring divider datapath.
//   clk, rst_n : clock, async active-low reset
//   load       : capture a_in/b_in and clear the step counter
//   step       : advance one bit of the operation
//   is_div     : 1 = restoring divide, 0 = shift-add multiply
//   a_in, b_in : unsigned multiplicand/dividend, multiplier/divisor
//   acc        : {hi, lo} = product, or {remainder, quotient}
//   last       : current step is the final one (counter == WIDTH-1)
module mdu_shift_core import mdu_pkg::*; #(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic [2*WIDTH-1:0] acc,
    output logic               last
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   hi, lo;
    logic [WIDTH:0]     opnd_x, sum;

    assign hi = acc_q[2*WIDTH-1:WIDTH];
    assign lo = acc_q[WIDTH-1:0];

    // One shared adder/subtractor. Divide keeps remainder < divisor, so a
    // non-negative difference always has sum[WIDTH] clear and a borrow sets it.
    always_comb begin
        opnd_x = is_div ? {hi, lo[WIDTH-1]} : {1'b0, hi};
        sum    = is_div ? (opnd_x - {1'b0, b_q}) : (opnd_x + {1'b0, b_q});
        acc_d  = acc_q;
        if (is_div) begin
            if (!sum[WIDTH]) begin
                acc_d = {sum[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {opnd_x[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Multiplier bits shift out of lo as product bits shift in from hi.
            if (lo[0]) begin
                acc_d = {sum, lo[WIDTH-1:1]};
            end else begin
                acc_d = {1'b0, hi, lo[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else if (load) begin
            acc_q <= {{WIDTH{1'b0}}, a_in};
            b_q   <= b_in;
            cnt_q <= '0;
        end else if (step) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign acc  = acc_q;
    assign last = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit (MULTU, DIVU, MULT, DIV).
//   clk, rst_n           : clock, async active-low reset
//   start, op            : request and operation select (sampled when ready)
//   operand_a, operand_b : multiplicand/dividend, multiplier/divisor
//   dest_addr            : writeback register, captured at start
//   kill                 : abort the operation in flight
//   busy                 : high in RUN and FIX
//   done                 : one-cycle result strobe
//   result_lo/result_hi  : product low/high, or quotient/remainder
//   wr_addr              : captured dest_addr
//   div_by_zero          : divide with zero divisor, valid with done
module mul_div_unit import mdu_pkg::*; #(
    parameter int unsigned WIDTH  = MDU_WIDTH,
    parameter int unsigned ADDR_W = MDU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  operand_a,
    input  logic [WIDTH-1:0]  operand_b,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic              kill,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result_lo,
    output logic [WIDTH-1:0]  result_hi,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              div_by_zero
);

    state_e             state_q;
    op_e                op_q;
    logic               neg_q, rem_neg_q, b_zero_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic [ADDR_W-1:0]  dest_q;

    logic               accept, is_div_q, a_neg, b_neg, last;
    logic [WIDTH-1:0]   a_mag, b_mag, lo_d, hi_d, quo, rem;
    logic [2*WIDTH-1:0] acc, prod;

    assign accept   = ((state_q == StIdle) || (state_q == StDone)) && start && !kill;
    assign is_div_q = (op_q == OP_DIVU) || (op_q == OP_DIV);

    // Magnitudes of the live operands; used only on the capture edge.
    assign a_neg = op[1] && operand_a[WIDTH-1];
    assign b_neg = op[1] && operand_b[WIDTH-1];
    assign a_mag = a_neg ? -operand_a : operand_a;
    assign b_mag = b_neg ? -operand_b : operand_b;

    mdu_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .step   (state_q == StRun),
        .is_div (is_div_q),
        .a_in   (a_mag),
        .b_in   (b_mag),
        .acc    (acc),
        .last   (last)
    );

    // Sign correction applied in FIX. 0x8000 / -1 needs no special case: the
    // magnitude quotient 0x8000 with a positive sign is already the answer.
    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = acc[WIDTH-1:0];
        rem  = acc[2*WIDTH-1:WIDTH];
        lo_d = prod[WIDTH-1:0];
        hi_d = prod[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            if (b_zero_q) begin
                lo_d = '1;
                hi_d = a_raw_q;
            end else begin
                lo_d = neg_q ? -quo : quo;
                hi_d = rem_neg_q ? -rem : rem;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= OP_MULTU;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            b_zero_q    <= 1'b0;
            a_raw_q     <= '0;
            dest_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
            wr_addr     <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        state_q   <= StRun;
                        busy      <= 1'b1;
                        op_q      <= op_e'(op);
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        b_zero_q  <= (operand_b == '0);
                        a_raw_q   <= operand_a;
                        dest_q    <= dest_addr;
                    end else begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
                StRun: begin
                    if (kill) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else if (last) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    busy <= 1'b0;
                    if (kill) begin
                        state_q <= StIdle;
                    end else begin
                        state_q     <= StDone;
                        done        <= 1'b1;
                        result_lo   <= lo_d;
                        result_hi   <= hi_d;
                        wr_addr     <= dest_q;
                        div_by_zero <= is_div_q && b_zero_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
